// File: rtl/burst_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : burst_receiver_if
//  Description : Router-side flit input, local FIFO read port and
//                transaction status signals of the burst receiver.
//  Revision    : 1.0  initial release
// ============================================================================
interface burst_receiver_if;
    logic [8:0] data_from_router;
    logic [1:0] src_id;
    logic       processor_ready;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       fifo_empty;
    logic [4:0] fifo_count;
    logic       transfer_done;
    logic [1:0] done_src;
    logic [7:0] done_len;
    logic       overflow_err;
    logic       timeout_err;

    modport slave (
        input  data_from_router, src_id, rd_en,
        output processor_ready, rd_data, fifo_empty, fifo_count,
               transfer_done, done_src, done_len, overflow_err, timeout_err
    );

    modport master (
        output data_from_router, src_id, rd_en,
        input  processor_ready, rd_data, fifo_empty, fifo_count,
               transfer_done, done_src, done_len, overflow_err, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/burst_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : burst_receiver
//  Description : Receives header + payload flit bursts into a show-ahead FIFO
//                and reports per-transaction completion and sticky errors.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_receiver #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic         clock,
    input  wire logic         reset,
    burst_receiver_if.slave   bus
);
    localparam int         PW        = $clog2(DEPTH);
    localparam logic [4:0] DEPTH_C   = 5'(DEPTH);
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RECV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      remaining_q, remaining_d;
    logic [1:0]      src_q, src_d;
    logic [7:0]      stored_q, stored_d;
    logic [7:0]      idle_q, idle_d;
    logic [1:0]      done_src_q, done_src_d;
    logic [7:0]      done_len_q, done_len_d;
    logic            ovf_q, ovf_d;
    logic            tmo_q, tmo_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [4:0]      count_q, count_d;
    logic [7:0]      mem_q [DEPTH];

    logic            flit_valid;
    logic [7:0]      flit_data;
    logic            push;
    logic            pop;
    logic            full;

    assign flit_valid = bus.data_from_router[8];
    assign flit_data  = bus.data_from_router[7:0];
    assign full       = (count_q == DEPTH_C);
    assign pop        = bus.rd_en && (count_q != 5'd0);

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        src_d       = src_q;
        stored_d    = stored_q;
        idle_d      = idle_q;
        done_src_d  = done_src_q;
        done_len_d  = done_len_q;
        ovf_d       = ovf_q;
        tmo_d       = tmo_q;
        push        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flit_valid) begin
                    remaining_d = flit_data;
                    src_d       = bus.src_id;
                    stored_d    = 8'd0;
                    idle_d      = 8'd0;
                    if (flit_data == 8'd0) begin
                        state_d    = S_DONE;
                        done_src_d = bus.src_id;
                        done_len_d = 8'd0;
                    end else begin
                        state_d = S_RECV;
                    end
                end
            end
            S_RECV: begin
                if (flit_valid) begin
                    idle_d      = 8'd0;
                    remaining_d = remaining_q - 8'd1;
                    // A same-cycle pop frees the slot even when currently full.
                    if (!full || pop) begin
                        push     = 1'b1;
                        stored_d = stored_q + 8'd1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (remaining_q == 8'd1) begin
                        state_d    = S_DONE;
                        done_src_d = src_q;
                        done_len_d = stored_d;
                    end
                end else begin
                    idle_d = idle_q + 8'd1;
                    if (idle_d == TIMEOUT_C) begin
                        state_d    = S_DONE;
                        tmo_d      = 1'b1;
                        done_src_d = src_q;
                        done_len_d = stored_q;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {4'd0, push} - {4'd0, pop};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            src_q       <= 2'd0;
            stored_q    <= 8'd0;
            idle_q      <= 8'd0;
            done_src_q  <= 2'd0;
            done_len_q  <= 8'd0;
            ovf_q       <= 1'b0;
            tmo_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 5'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            src_q       <= src_d;
            stored_q    <= stored_d;
            idle_q      <= idle_d;
            done_src_q  <= done_src_d;
            done_len_q  <= done_len_d;
            ovf_q       <= ovf_d;
            tmo_q       <= tmo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage needs no reset: the read port is masked to zero while empty.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem_q[wr_ptr_q] <= flit_data;
        end
    end

    assign bus.processor_ready = (state_q == S_IDLE) && (count_q < DEPTH_C);
    assign bus.fifo_empty      = (count_q == 5'd0);
    assign bus.fifo_count      = count_q;
    assign bus.rd_data         = (count_q == 5'd0) ? 8'd0 : mem_q[rd_ptr_q];
    assign bus.transfer_done   = (state_q == S_DONE);
    assign bus.done_src        = done_src_q;
    assign bus.done_len        = done_len_q;
    assign bus.overflow_err    = ovf_q;
    assign bus.timeout_err     = tmo_q;
endmodule
`default_nettype wire

// File: tb/tb_burst_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_receiver
//  Description : Directed self-checking bench for burst_receiver (DEPTH=8,
//                TIMEOUT=4).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_receiver;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   pulses   = 0;
    int   pulses_snap;

    burst_receiver_if bus ();

    burst_receiver #(
        .DEPTH   (8),
        .TIMEOUT (4)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.transfer_done === 1'b1) pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input logic v, input logic [7:0] d, input logic rd);
        bus.data_from_router = {v, d};
        bus.rd_en            = rd;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.data_from_router = 9'd0;
        bus.rd_en            = 1'b0;
        reset                = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.data_from_router = 9'd0;
        bus.src_id           = 2'd0;
        bus.rd_en            = 1'b0;
        reset                = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_ready",  32'(bus.processor_ready), 32'd1);
        check("rst_empty",  32'(bus.fifo_empty),      32'd1);
        check("rst_count",  32'(bus.fifo_count),      32'd0);
        check("rst_rdata",  32'(bus.rd_data),         32'd0);
        check("rst_done",   32'(bus.transfer_done),   32'd0);
        check("rst_dsrc",   32'(bus.done_src),        32'd0);
        check("rst_dlen",   32'(bus.done_len),        32'd0);
        check("rst_errs",   32'({bus.overflow_err, bus.timeout_err}), 32'd0);
        reset = 1'b0;

        // Three-flit burst from source 2
        bus.src_id = 2'd2;
        cyc(1'b1, 8'h03, 1'b0);
        check("t1_ready_recv", 32'(bus.processor_ready), 32'd0);
        bus.src_id = 2'd0;
        cyc(1'b1, 8'hA1, 1'b0);
        check("t1_count1", 32'(bus.fifo_count), 32'd1);
        check("t1_rdata1", 32'(bus.rd_data),    32'hA1);
        cyc(1'b1, 8'hA2, 1'b0);
        check("t1_done_early", 32'(bus.transfer_done), 32'd0);
        cyc(1'b1, 8'hA3, 1'b0);
        check("t1_done",  32'(bus.transfer_done), 32'd1);
        check("t1_dsrc",  32'(bus.done_src),      32'd2);
        check("t1_dlen",  32'(bus.done_len),      32'd3);
        check("t1_count", 32'(bus.fifo_count),    32'd3);
        cyc(1'b0, 8'h00, 1'b0);
        check("t1_done_off", 32'(bus.transfer_done), 32'd0);
        check("t1_ready",    32'(bus.processor_ready), 32'd1);
        check("t1_dlen_hold", 32'(bus.done_len), 32'd3);
        cyc(1'b0, 8'h00, 1'b1);
        check("t1_pop1", 32'(bus.rd_data), 32'hA2);
        cyc(1'b0, 8'h00, 1'b1);
        check("t1_pop2", 32'(bus.rd_data), 32'hA3);
        cyc(1'b0, 8'h00, 1'b1);
        check("t1_drained", 32'({bus.fifo_empty, bus.rd_data}), 32'h100);
        cyc(1'b0, 8'h00, 1'b1);
        check("t1_pop_empty", 32'(bus.fifo_count), 32'd0);

        // Zero-length header from source 1
        bus.src_id = 2'd1;
        cyc(1'b1, 8'h00, 1'b0);
        check("t2_done",  32'(bus.transfer_done), 32'd1);
        check("t2_dsrc",  32'(bus.done_src),      32'd1);
        check("t2_dlen",  32'(bus.done_len),      32'd0);
        check("t2_count", 32'(bus.fifo_count),    32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("t2_ready", 32'(bus.processor_ready), 32'd1);
        check("t2_done_off", 32'(bus.transfer_done), 32'd0);

        // Ten flits into an 8-deep FIFO with no reads
        bus.src_id = 2'd0;
        cyc(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0);
        check("t3_done",  32'(bus.transfer_done), 32'd1);
        check("t3_dlen",  32'(bus.done_len),      32'd8);
        check("t3_count", 32'(bus.fifo_count),    32'd8);
        check("t3_ovf",   32'(bus.overflow_err),  32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        check("t3_ready_full", 32'(bus.processor_ready), 32'd0);
        check("t3_head", 32'(bus.rd_data), 32'h10);
        cyc(1'b0, 8'h00, 1'b1);
        check("t3_ready_pop", 32'(bus.processor_ready), 32'd1);
        check("t3_count_pop", 32'(bus.fifo_count), 32'd7);
        check("t3_rdata_pop", 32'(bus.rd_data), 32'h11);
        check("t3_ovf_sticky", 32'(bus.overflow_err), 32'd1);
        do_reset();
        check("t3_ovf_rst", 32'(bus.overflow_err), 32'd0);

        // Same burst with reads on the 9th and 10th flit cycles
        bus.src_id = 2'd3;
        cyc(1'b1, 8'h0A, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + i), (i >= 8));
        check("t4_done",  32'(bus.transfer_done), 32'd1);
        check("t4_dsrc",  32'(bus.done_src),      32'd3);
        check("t4_dlen",  32'(bus.done_len),      32'd10);
        check("t4_count", 32'(bus.fifo_count),    32'd8);
        check("t4_ovf",   32'(bus.overflow_err),  32'd0);
        check("t4_head",  32'(bus.rd_data),       32'h22);
        do_reset();

        // Idle timeout after two of five flits
        bus.src_id = 2'd1;
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'hB1, 1'b0);
        cyc(1'b1, 8'hB2, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        check("t5_no_done_yet", 32'({bus.transfer_done, bus.timeout_err}), 32'd0);
        cyc(1'b0, 8'h00, 1'b0);
        check("t5_done", 32'(bus.transfer_done), 32'd1);
        check("t5_tmo",  32'(bus.timeout_err),   32'd1);
        check("t5_dlen", 32'(bus.done_len),      32'd2);
        check("t5_dsrc", 32'(bus.done_src),      32'd1);
        cyc(1'b1, 8'hEE, 1'b0);
        check("t5_done_ignored", 32'(bus.fifo_count), 32'd2);
        cyc(1'b0, 8'h00, 1'b0);
        check("t5_tmo_sticky", 32'(bus.timeout_err), 32'd1);
        do_reset();

        // Reset in the middle of a burst, coinciding with a valid flit
        bus.src_id = 2'd2;
        cyc(1'b1, 8'h05, 1'b0);
        cyc(1'b1, 8'hC1, 1'b0);
        cyc(1'b1, 8'hC2, 1'b0);
        bus.data_from_router = 9'h1C3;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        pulses_snap = pulses;
        check("t6_empty", 32'(bus.fifo_empty),      32'd1);
        check("t6_ready", 32'(bus.processor_ready), 32'd1);
        check("t6_tmo",   32'(bus.timeout_err),     32'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0);
        check("t6_no_pulse", 32'(pulses - pulses_snap), 32'd0);
        bus.src_id = 2'd0;
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'hD1, 1'b0);
        check("t6_done",  32'(bus.transfer_done), 32'd1);
        check("t6_dlen",  32'(bus.done_len),      32'd1);
        check("t6_dsrc",  32'(bus.done_src),      32'd0);
        check("t6_rdata", 32'(bus.rd_data),       32'hD1);
        cyc(1'b0, 8'h00, 1'b0);
        check("t6_one_pulse", 32'(pulses - pulses_snap), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
